// File: rtl/multicycle_alu.sv
// EX-stage ALU: logic, add and LUI finish in one cycle; SLL/SRL run an
// iterative one-bit-per-cycle shifter behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   Overflow,
  output logic                   Error,
  output logic                   busy,
  output logic                   done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_LUI = 4'b1000;

  localparam logic [SHAMT_WIDTH-1:0] CNT_ONE = SHAMT_WIDTH'(1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e                 state_q,  state_d;
  logic [DATA_WIDTH-1:0]  shreg_q,  shreg_d;
  logic [SHAMT_WIDTH-1:0] cnt_q,    cnt_d;
  logic                   dir_q,    dir_d;     // 1 = shift right
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q,   zero_d;
  logic                   ovf_q,    ovf_d;
  logic                   err_q,    err_d;
  logic                   done_q,   done_d;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] op_result;
  logic                  op_ovf;
  logic                  op_err;
  logic                  is_shift;
  logic [DATA_WIDTH-1:0] shreg_step;

  // Single-cycle datapath; a shift by zero simply passes B through.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    sum       = A + B;
    op_result = '0;
    op_ovf    = 1'b0;
    op_err    = 1'b0;
    is_shift  = 1'b0;
    case (ALUOperation)
      OP_AND: op_result = A & B;
      OP_OR:  op_result = A | B;
      OP_NOR: op_result = ~(A | B);
      OP_ADD: begin
        op_result = sum;
        op_ovf    = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                    (sum[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
      end
      OP_SLL, OP_SRL: begin
        op_result = B;
        is_shift  = 1'b1;
      end
      OP_LUI: op_result = {B[DATA_WIDTH/2-1:0], {(DATA_WIDTH/2){1'b0}}};
      default: op_err = 1'b1;
    endcase
  end

  assign shreg_step = dir_q ? (shreg_q >> 1) : (shreg_q << 1);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_shift && (shamt != '0)) begin
            state_d = S_SHIFT;
            shreg_d = B;
            cnt_d   = shamt;
            dir_d   = (ALUOperation == OP_SRL);
          end else begin
            result_d = op_result;
            zero_d   = (op_result == '0);
            ovf_d    = op_ovf;
            err_d    = op_err;
            done_d   = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_step;
        cnt_d   = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = S_IDLE;
          result_d = shreg_step;
          zero_d   = (shreg_step == '0);
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Error     = err_q;
  assign done      = done_q;
  assign busy      = (state_q == S_SHIFT);

endmodule
